// File: rtl/aftab_aau_mul_sequencer_if.sv
// aftab_aau_mul_sequencer_if: core request/response and Booth launch/product signals of the AAU multiply sequencer.
interface aftab_aau_mul_sequencer_if #(parameter int len = 32);
  logic              startAAU;
  logic [1:0]        funct;
  logic              flush;
  logic [len-1:0]    opA;
  logic [len-1:0]    opB;
  logic [len-1:0]    result;
  logic              completeAAU;
  logic              busy;
  logic              startBooth;
  logic [len:0]      boothM;
  logic [len:0]      boothMr;
  logic              boothDone;
  logic [2*len+1:0]  boothP;
  modport master (
    output startAAU, funct, flush, opA, opB, boothDone, boothP,
    input  result, completeAAU, busy, startBooth, boothM, boothMr
  );
  modport slave (
    input  startAAU, funct, flush, opA, opB, boothDone, boothP,
    output result, completeAAU, busy, startBooth, boothM, boothMr
  );
endinterface

// File: rtl/aftab_aau_mul_sequencer.sv
// aftab_aau_mul_sequencer: issues M-extension multiplies to the Booth unit and returns the selected product half.
// Optional AAU_MUL_ZERO_BYPASS_EN: zero operands complete straight from IDLE without launching the Booth unit.
module aftab_aau_mul_sequencer #(
  parameter int len = 32
) (
  input logic clk,
  input logic rst,
  aftab_aau_mul_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;
  state_t         state_q, state_d;
  logic [1:0]     funct_q, funct_d;
  logic [len-1:0] result_q, result_d;
  logic [len:0]   m_q, m_d, mr_q, mr_d;
  logic           zero_op;
  logic           unused_hi;
`ifdef AAU_MUL_ZERO_BYPASS_EN
  assign zero_op = ~|bus.opA | ~|bus.opB;
`else
  assign zero_op = 1'b0;
`endif
  assign unused_hi = ^bus.boothP[2*len+1:2*len];
  always_comb begin
    state_d  = state_q;
    funct_d  = funct_q;
    result_d = result_q;
    m_d      = m_q;
    mr_d     = mr_q;
    if (bus.flush) state_d = IDLE;
    else begin
      unique case (state_q)
        IDLE: if (bus.startAAU) begin
          funct_d  = bus.funct;
          // opA is unsigned only for MULHU; opB is unsigned for MULHSU and MULHU
          m_d      = {(bus.funct != 2'b11) & bus.opA[len-1], bus.opA};
          mr_d     = {~bus.funct[1] & bus.opB[len-1], bus.opB};
          state_d  = zero_op ? DONE : LAUNCH;
          result_d = zero_op ? '0 : result_q;
        end
        LAUNCH: state_d = WAIT;
        WAIT: if (bus.boothDone) begin
          result_d = (funct_q == 2'b00) ? bus.boothP[len-1:0] : bus.boothP[2*len-1:len];
          state_d  = DONE;
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      funct_q  <= '0;
      result_q <= '0;
      m_q      <= '0;
      mr_q     <= '0;
    end else begin
      state_q  <= state_d;
      funct_q  <= funct_d;
      result_q <= result_d;
      m_q      <= m_d;
      mr_q     <= mr_d;
    end
  end
  assign bus.result      = result_q;
  assign bus.completeAAU = state_q == DONE;
  assign bus.busy        = state_q == LAUNCH || state_q == WAIT;
  assign bus.startBooth  = state_q == LAUNCH;
  assign bus.boothM      = m_q;
  assign bus.boothMr     = mr_q;
endmodule

// File: tb/tb_aftab_aau_mul_sequencer.sv
// tb_aftab_aau_mul_sequencer: directed multiply, flush, reset and back-to-back vectors with hand-computed results.
module tb_aftab_aau_mul_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  aftab_aau_mul_sequencer_if #(.len(32)) bus ();
  aftab_aau_mul_sequencer #(.len(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic op(input string tag, input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                    input logic [32:0] em, input logic [32:0] emr, input int lat,
                    input logic [31:0] exp, input bit poke);
    logic signed [65:0] ms, mrs, p;
    int nstart, ncomp, nbusy;
    bus.startAAU = 1'b1; bus.funct = f; bus.opA = a; bus.opB = b;
    tick();
    bus.startAAU = 1'b0; bus.opA = 32'h1234_5678; bus.opB = 32'h9abc_def0;
    chk($sformatf("%s_startBooth", tag), bus.startBooth, 1'b1);
    chk($sformatf("%s_busy_launch", tag), bus.busy, 1'b1);
    chk($sformatf("%s_boothM", tag), bus.boothM, em);
    chk($sformatf("%s_boothMr", tag), bus.boothMr, emr);
    ms = $signed(bus.boothM);
    mrs = $signed(bus.boothMr);
    p = ms * mrs;
    nstart = 0; ncomp = 0; nbusy = 0;
    for (int i = 0; i < lat; i++) begin
      bus.startAAU = poke && i == lat / 2;
      tick();
      nstart += int'(bus.startBooth);
      ncomp += int'(bus.completeAAU);
      nbusy += int'(!bus.busy);
    end
    bus.startAAU = 1'b0;
    chk($sformatf("%s_extra_start", tag), 66'(nstart), 66'd0);
    chk($sformatf("%s_early_complete", tag), 66'(ncomp), 66'd0);
    chk($sformatf("%s_busy_wait", tag), 66'(nbusy), 66'd0);
    bus.boothDone = 1'b1; bus.boothP = p;
    #1 chk($sformatf("%s_busy_capture", tag), bus.busy, 1'b1);
    tick();
    bus.boothDone = 1'b0; bus.boothP = {66{1'b1}};
    chk($sformatf("%s_complete", tag), bus.completeAAU, 1'b1);
    chk($sformatf("%s_busy_done", tag), bus.busy, 1'b0);
    chk($sformatf("%s_result", tag), bus.result, exp);
    bus.startAAU = poke;
    tick();
    bus.startAAU = 1'b0;
    chk($sformatf("%s_complete_once", tag), bus.completeAAU, 1'b0);
    chk($sformatf("%s_idle_after", tag), {bus.busy, bus.startBooth}, 2'b00);
    chk($sformatf("%s_boothM_hold", tag), bus.boothM, em);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] prev;
    bus.startAAU = 1'b0; bus.funct = 2'b00; bus.flush = 1'b0;
    bus.opA = '0; bus.opB = '0; bus.boothDone = 1'b0; bus.boothP = '0;
    #12;
    chk("rst_result", bus.result, 32'h0);
    chk("rst_ctrl", {bus.completeAAU, bus.busy, bus.startBooth}, 3'b000);
    chk("rst_boothM", {bus.boothM, bus.boothMr}, 66'h0);
    tick();
    rst = 1'b1;
    tick();
    op("mul", 2'b00, 32'h7, 32'hFFFF_FFFD, 33'h0_0000_0007, 33'h1_FFFF_FFFD, 3, 32'hFFFF_FFEB, 1'b0);
    op("mulh", 2'b01, 32'h8000_0000, 32'h8000_0000, 33'h1_8000_0000, 33'h1_8000_0000, 2, 32'h4000_0000, 1'b0);
    op("mulhu", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF, 5, 32'hFFFF_FFFE, 1'b0);
    op("mulhsu", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFF, 33'h0_FFFF_FFFF, 1, 32'hFFFF_FFFF, 1'b0);
    op("slow", 2'b00, 32'h3, 32'h5, 33'h0_0000_0003, 33'h0_0000_0005, 40, 32'h0000_000F, 1'b1);
    op("b2b", 2'b01, 32'h0001_0000, 32'hFFFF_0000, 33'h0_0001_0000, 33'h1_FFFF_0000, 2, 32'hFFFF_FFFF, 1'b0);
`ifdef AAU_MUL_ZERO_BYPASS_EN
    bus.startAAU = 1'b1; bus.funct = 2'b00; bus.opA = 32'h0; bus.opB = 32'h5;
    tick();
    bus.startAAU = 1'b0;
    chk("zero_complete", bus.completeAAU, 1'b1);
    chk("zero_no_launch", {bus.busy, bus.startBooth}, 2'b00);
    chk("zero_result", bus.result, 32'h0);
    tick();
    chk("zero_idle", bus.completeAAU, 1'b0);
`else
    op("zero", 2'b00, 32'h0, 32'h5, 33'h0_0000_0000, 33'h0_0000_0005, 2, 32'h0, 1'b0);
`endif
    op("pre_flush", 2'b00, 32'h11, 32'h3, 33'h0_0000_0011, 33'h0_0000_0003, 2, 32'h33, 1'b0);
    prev = 32'h33;
    bus.boothDone = 1'b1; bus.boothP = {66{1'b1}};
    tick();
    bus.boothDone = 1'b0;
    chk("idle_done_ignored", bus.completeAAU, 1'b0);
    chk("idle_done_result", bus.result, prev);
    bus.flush = 1'b1; bus.startAAU = 1'b1; bus.opA = 32'h2; bus.opB = 32'h2;
    tick();
    bus.flush = 1'b0; bus.startAAU = 1'b0;
    chk("flush_beats_start", {bus.busy, bus.startBooth}, 2'b00);
    bus.startAAU = 1'b1; bus.funct = 2'b11; bus.opA = 32'h2; bus.opB = 32'h9;
    tick();
    bus.startAAU = 1'b0;
    tick();
    tick();
    chk("flush_pre_busy", bus.busy, 1'b1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_ctrl", {bus.completeAAU, bus.busy, bus.startBooth}, 3'b000);
    bus.boothDone = 1'b1; bus.boothP = 66'h0_0000_0001_0000_0012;
    tick();
    bus.boothDone = 1'b0;
    chk("flush_no_complete", bus.completeAAU, 1'b0);
    chk("flush_result", bus.result, prev);
    tick();
    chk("flush_still_idle", {bus.completeAAU, bus.busy}, 2'b00);
    bus.startAAU = 1'b1; bus.funct = 2'b00; bus.opA = 32'h6; bus.opB = 32'h7;
    tick();
    bus.startAAU = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_mid_ctrl", {bus.completeAAU, bus.busy, bus.startBooth}, 3'b000);
    chk("rst_mid_result", bus.result, 32'h0);
    chk("rst_mid_booth", {bus.boothM, bus.boothMr}, 66'h0);
    tick();
    rst = 1'b1;
    tick();
    chk("rst_release_idle", {bus.busy, bus.startBooth}, 2'b00);
    op("after_rst", 2'b00, 32'h6, 32'h7, 33'h0_0000_0006, 33'h0_0000_0007, 2, 32'h2A, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
